// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/sub, one CW-bit chunk per stage with registered carry,
// operand skew and result deskew carried in one shrinking per-stage data word.
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic             w_cx;
    logic             w_ovf;
    logic             r_ovf;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_bx     = sub ? ~b : b;
    assign w_cx     = cin ^ sub;

    // Stage k word layout: {b not yet consumed, a not yet consumed, sum chunks done}.
    // It shrinks by CW each stage, so the last stage holds exactly the result.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            localparam int PW = 2*WIDTH - k*CW;
            localparam int NW = PW - CW;
            logic [PW-1:0]    w_p;
            logic             w_pv;
            logic             w_pc;
            logic [CW:0]      w_t;
            logic [WIDTH-1:0] w_low;
            logic [NW-1:0]    w_n;
            logic [NW-1:0]    r_x;
            logic             r_v;
            logic             r_c;
            if (k == 0) begin : g_src
                assign w_p  = {w_bx, a};
                assign w_pv = in_valid;
                assign w_pc = w_cx;
            end else begin : g_src
                assign w_p  = g_st[k-1].r_x;
                assign w_pv = g_st[k-1].r_v;
                assign w_pc = g_st[k-1].r_c;
            end
            assign w_t = {1'b0, w_p[k*CW +: CW]} + {1'b0, w_p[WIDTH +: CW]} + {{CW{1'b0}}, w_pc};
            always_comb begin
                w_low = w_p[WIDTH-1:0];
                w_low[k*CW +: CW] = w_t[CW-1:0];
            end
            if (k == L) begin : g_n
                assign w_n = w_low;
            end else begin : g_n
                assign w_n = {w_p[PW-1:WIDTH+CW], w_low};
            end
            // Data only loads with a valid beat so bubbles leave the outputs untouched.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_x <= '0;
                end else if (w_adv) begin
                    r_v <= w_pv;
                    if (w_pv) begin
                        r_c <= w_t[CW];
                        r_x <= w_n;
                    end
                end
            end
        end
    endgenerate

    // Carry into the MSB recovered as a ^ b ^ sum at that bit.
    assign w_ovf = g_st[L].w_p[WIDTH-1] ^ g_st[L].w_p[WIDTH+CW-1] ^ g_st[L].w_t[CW-1] ^ g_st[L].w_t[CW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_adv && g_st[L].w_pv)
            r_ovf <= w_ovf;
    end

    assign out_valid = g_st[L].r_v;
    assign sum       = g_st[L].r_x;
    assign cout      = g_st[L].r_c;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and streaming checks of adder_pipe, plus a parameter sweep.
module tb_adder_pipe;
    logic        clk = 0, rst = 0;
    logic        in_valid = 0, out_ready = 1, cin = 0, sub = 0;
    logic [15:0] a = 0, b = 0;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;
    int          checks = 0, errors = 0, cyc = 0;

    logic        sw_valid = 0, sw_cin = 0, sw_sub = 0;
    logic [31:0] sw_a = 0, sw_b = 0;
    logic [3:0]  sw_ir, sw_ov, sw_co, sw_of;
    logic [3:0]  s0;
    logic [7:0]  s1;
    logic [31:0] s2;
    logic [15:0] s3;
    logic [65:0] q_exp[4][$];
    int          q_cyc[4][$];
    logic [17:0] q_main[$];
    int          sw_w[4] = '{4, 8, 32, 16};
    int          sw_s[4] = '{1, 2, 8, 16};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));
    adder_pipe #(.WIDTH(4), .STAGES(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]), .a(sw_a[3:0]), .b(sw_b[3:0]),
        .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[0]), .out_ready(1'b1),
        .sum(s0), .cout(sw_co[0]), .ovf(sw_of[0]));
    adder_pipe #(.WIDTH(8), .STAGES(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]), .a(sw_a[7:0]), .b(sw_b[7:0]),
        .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[1]), .out_ready(1'b1),
        .sum(s1), .cout(sw_co[1]), .ovf(sw_of[1]));
    adder_pipe #(.WIDTH(32), .STAGES(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]), .a(sw_a), .b(sw_b),
        .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[2]), .out_ready(1'b1),
        .sum(s2), .cout(sw_co[2]), .ovf(sw_of[2]));
    adder_pipe #(.WIDTH(16), .STAGES(16)) u3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[3]), .a(sw_a[15:0]), .b(sw_b[15:0]),
        .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[3]), .out_ready(1'b1),
        .sum(s3), .cout(sw_co[3]), .ovf(sw_of[3]));

    // Reference: {ovf, cout, sum[63:0]}; overflow from operand/result signs.
    function automatic logic [65:0] model(int w, logic [63:0] ma, logic [63:0] mb, logic mc, logic ms);
        logic [63:0] m, bb, s;
        logic [64:0] t;
        m  = (64'd1 << w) - 64'd1;
        bb = (ms ? ~mb : mb) & m;
        t  = {1'b0, ma & m} + {1'b0, bb} + {64'd0, ms ? ~mc : mc};
        s  = t[63:0] & m;
        return {(ma[w-1] == bb[w-1]) && (s[w-1] != ma[w-1]), t[w], s};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_sw(input int id, input logic v, input logic [63:0] s, input logic c, input logic o);
        logic [65:0] e;
        int ec;
        if (v) begin
            e  = q_exp[id].size() > 0 ? q_exp[id].pop_front() : 'x;
            ec = q_cyc[id].size() > 0 ? q_cyc[id].pop_front() : -1;
            chk($sformatf("sweep%0d_res", id), {o, c, s}, e);
            chk($sformatf("sweep%0d_lat", id), 66'(cyc), 66'(ec));
        end
    endtask

    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, input logic ts, input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        in_valid = 1; a = ta; b = tb; cin = tc; sub = ts; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; a = 16'($urandom); b = 16'($urandom);
        repeat (2) @(posedge clk);
        #1 chk({tag, "_early"}, 66'(out_valid), 66'(0));
        @(posedge clk);
        #1 chk({tag, "_res"}, {out_valid, ovf, cout, sum}, {1'b1, eo, ec, es});
        @(posedge clk);
        #1 chk({tag, "_after"}, {out_valid, sum}, {1'b0, es});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] m;
        logic [17:0] e, hv;
        logic        pend, held;
        int          sent, recv;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 chk("reset_out", {out_valid, cout, ovf, sum}, 66'(0));
        chk("reset_in_ready", 66'(in_ready), 66'(1));
        @(negedge clk) rst = 0;

        run_one("carry_ripple", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        run_one("ovf_add",      16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        run_one("ovf_sub",      16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        run_one("borrow",       16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        run_one("borrow_cin",   16'h0005, 16'h0007, 1, 1, 16'hFFFD, 0, 0);
        run_one("add_cin",      16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0);

        pend = 0; held = 0; sent = 0; recv = 0; hv = 0;
        for (int i = 0; i < 400 && recv < 32; i++) begin
            @(negedge clk);
            if (held) chk("stall_hold", {out_valid, ovf, cout, sum}, {1'b1, hv});
            out_ready = 1'($urandom_range(0, 1));
            if (!pend && sent < 32) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                pend = 1;
            end
            in_valid = pend;
            #1 chk("in_ready", 66'(in_ready), 66'(!out_valid || out_ready));
            if (in_valid && in_ready) begin
                m = model(16, 64'(a), 64'(b), cin, sub);
                q_main.push_back({m[65], m[64], m[15:0]});
                sent++;
                pend = 0;
            end
            if (out_valid && out_ready) begin
                e = q_main.size() > 0 ? q_main.pop_front() : 'x;
                chk("stream_res", {ovf, cout, sum}, e);
                recv++;
            end
            held = out_valid && !out_ready;
            hv = {ovf, cout, sum};
        end
        chk("stream_count", 66'(recv), 66'(32));
        chk("stream_empty", 66'(q_main.size()), 66'(0));
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        repeat (6) @(posedge clk);

        @(negedge clk);
        in_valid = 1; a = 16'hF0F0; b = 16'h1F1F; cin = 0; sub = 0;
        @(posedge clk);
        @(negedge clk) begin a = 16'h1111; b = 16'h2222; end
        @(posedge clk);
        @(negedge clk) begin a = 16'h3333; b = 16'h4444; end
        @(posedge clk);
        @(negedge clk) in_valid = 0;
        @(posedge clk);
        #1 chk("pre_reset", {out_valid, cout, ovf, sum}, {1'b1, 1'b1, 1'b0, 16'h100F});
        #2 rst = 1;
        #1 chk("async_reset", {out_valid, cout, ovf, sum}, 66'(0));
        chk("reset_ready", 66'(in_ready), 66'(1));
        @(posedge clk);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 chk("no_stale", 66'(out_valid), 66'(0));
        end
        run_one("after_reset", 16'h8000, 16'h8000, 1, 0, 16'h0001, 1, 1);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk_sw(0, sw_ov[0], 64'(s0), sw_co[0], sw_of[0]);
            chk_sw(1, sw_ov[1], 64'(s1), sw_co[1], sw_of[1]);
            chk_sw(2, sw_ov[2], 64'(s2), sw_co[2], sw_of[2]);
            chk_sw(3, sw_ov[3], 64'(s3), sw_co[3], sw_of[3]);
            if (i < 20) begin
                sw_valid = 1; sw_a = $urandom; sw_b = $urandom;
                sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
                for (int id = 0; id < 4; id++) begin
                    q_exp[id].push_back(model(sw_w[id], 64'(sw_a), 64'(sw_b), sw_cin, sw_sub));
                    q_cyc[id].push_back(cyc + sw_s[id]);
                end
            end else begin
                sw_valid = 0;
            end
        end
        for (int id = 0; id < 4; id++)
            chk($sformatf("sweep%0d_drain", id), 66'(q_exp[id].size()), 66'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined adder/subtractor. It is the multi-cycle successor to the team's combinational 4-bit ripple-carry adder. Operands are split into `STAGES` equal chunks, and one chunk is resolved per pipeline stage, with the carry registered between stages. This allows wide additions at high clock rates. It sits in the datapath behind a valid/ready stream source and delivers one result per cycle at full throughput, with backpressure support.

## Interface
- `WIDTH`, 16: operand/result width in bits. Must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth and number of chunks; chunk width `CW = WIDTH/STAGES`. Legal range is 1..WIDTH.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  the operand beat is valid.
- `in_ready`  output  1  the block accepts a beat this cycle.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in (add) / borrow-in (sub).
- `sub`  input  1  0 = add, 1 = subtract.
- `out_valid`  output  1  the result beat is valid.
- `out_ready`  input  1  the consumer accepts the result.
- `sum`  output  WIDTH  result.
- `cout`  output  1  carry-out. In subtract mode, 1 means no borrow.
- `ovf`  output  1  two's-complement signed overflow.

## Operation
- Add: `{cout,sum} = a + b + cin`.
- Subtract: `{cout,sum} = a + ~b + ~cin`, which equals `a - b - cin`.
- `ovf` = carry into MSB XOR carry out of MSB, computed in the final stage.
- Stage k (0..STAGES-1) adds chunk k of the operands plus the carry registered from stage k-1. Stage 0 uses the effective carry-in.
- Operand chunks not yet consumed are delayed alongside the pipeline (input skew).
- Result chunks already computed are delayed alongside the pipeline (output deskew). All `WIDTH` bits of a beat therefore emerge together.
- The `sub` inversion of `b` and `cin` is applied at input capture. No later stage needs `sub`.
- Each stage holds a valid bit. Bubbles propagate as invalid stages; data in invalid stages is don't-care, but `sum`/`cout`/`ovf` must be stable while `out_valid`=0 and not `out_ready`.
- Flow control is a global stall:
  - `advance = !out_valid || out_ready`.
  - When `advance`=1, every stage shifts forward by one.
  - When `advance`=0, all stage registers hold.
- `in_ready = advance`. A beat is accepted when `in_valid && in_ready`.
- The result is consumed when `out_valid && out_ready`.
- Ordering is strict FIFO. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid`/`sum` after edge N+STAGES-1. Its first registered appearance is at the output after `STAGES` edges counted from the capture edge, with no stalls. With `STAGES`=1, the result is registered one cycle after acceptance.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: `in_ready` falls in the same cycle that `out_valid`=1 and `out_ready`=0, combinationally from `out_ready`. `out_valid`, `sum`, `cout` and `ovf` hold until consumed.
- Simultaneous output consume and input accept in one cycle is legal and required for full throughput.
- Input changes while `in_ready`=0 have no effect.
- Reset, asserted at any time including mid-stream:
  - All stage valid bits, carries and data registers clear immediately.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - In-flight beats are discarded.
  - `in_ready`=1 during and after reset, since `out_valid`=0.
- First accept is possible on the first rising edge after `rst` deasserts.

## Test plan
- Full carry ripple (WIDTH=16, STAGES=4): a=FFFF, b=0001, cin=0, sub=0, out_ready=1 -> after 4 cycles `sum`=0000, `cout`=1, `ovf`=0; carry crosses every chunk boundary.
- Signed overflow, both modes:
  - a=7FFF, b=0001, add -> `sum`=8000, `cout`=0, `ovf`=1.
  - a=8000, b=0001, sub, cin=0 -> `sum`=7FFF, `cout`=1, `ovf`=1.
- Borrow: a=0005, b=0007, sub=1, cin=0 -> `sum`=FFFE, `cout`=0, `ovf`=0.
  - Same operands with cin=1 -> `sum`=FFFD, `cout`=0.
- Streaming with backpressure:
  - Stimulus: 32 random back-to-back beats; `out_ready` random ~50%.
  - Response: results match the reference model in order, none lost or duplicated. `in_ready` equals `!out_valid || out_ready` every cycle. Output stays stable while stalled.
- Reset mid-operation: `rst` asserted asynchronously with 3 beats in flight -> `out_valid`, `sum`, `cout`, `ovf` go to 0 before the next edge; no stale beat appears after release; the next beat has correct latency.
- Parameter sweep: (WIDTH, STAGES) = (4,1), (8,2), (32,8), (16,16) with exhaustive or random vectors -> all match the model at latency `STAGES`.
